byte_deserializer: RTL

- Asynchronous-serial receive front end: recovers 8-bit bytes from a single idle-high serial line (start bit, 8 data bits LSB first, optional even parity, 1 stop bit).
- Sits directly upstream of the 8-bit holding register. byte_out drives that register's data input; byte_valid drives its load enable.
- Oversamples the line at CLKS_PER_BIT clocks per bit and flags parity and framing errors.

---
 rtl/byte_deserializer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/byte_deserializer.sv
// -----------------------------------------------------------------------------
// byte_deserializer
//
// Asynchronous-serial receive front end. Recovers 8-bit bytes from an
// idle-high serial line framed as: start bit (0), 8 data bits LSB first,
// optional even parity bit, 1 stop bit (1). The line is oversampled at
// CLKS_PER_BIT clocks per bit. Each bit is sampled once, at its centre.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (>= 2); mid-bit offset is CPB/2
//   PARITY_EN     1 = even-parity bit follows the data bits, 0 = none
//
// Ports:
//   CLK         clock, all flops on the rising edge
//   reset       asynchronous, active-high reset
//   rx_in       serial line, idle high, asynchronous to CLK
//   byte_out    last good received byte, held until the next good byte
//   byte_valid  one-cycle pulse when byte_out has just been updated
//   parity_err  one-cycle pulse on a parity mismatch
//   frame_err   one-cycle pulse when the stop bit samples 0
//   busy        high in every state except IDLE (registered)
//   fsm_state   debug view of the receive FSM state
//                 (0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP, 5 WAIT_IDLE)
//
// Timing: rx_in passes through a 2-flop synchronizer (rx_s). If rx_s is first
// seen low in cycle t0, then bit k is sampled at t0 + CPB/2 + k*CPB. The
// start bit is k = 0, the data bits are k = 1..8 and the parity bit is k = 9.
// The stop bit is k = 9 + PARITY_EN. The result pulse appears one cycle after
// the stop sample.
// -----------------------------------------------------------------------------
module byte_deserializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] fsm_state
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  // The START state is entered one cycle after t0 with the counter at 0.
  // The counter therefore reads m-1 in cycle t0+m.
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  logic          sync1;
  logic          rx_s;
  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bad;
  logic          sample;

  assign fsm_state = state;

  // Two-flop synchronizer. Both flops reset to the idle (high) level, so
  // reset never produces a false start edge.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rx_s  <= sync1;
    end
  end

  // Next-state logic. The sample signal marks the single centre-of-bit
  // cycle in which rx_s is consumed by the current state.
  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) state_nxt = S_START;
      end
      S_START: begin
        if (clk_cnt == HALF_M1) begin
          sample    = 1'b1;
          // A high line at mid-start is a glitch and is dropped silently.
          state_nxt = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (clk_cnt == LAST) begin
          sample = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (clk_cnt == LAST) begin
          sample    = 1'b1;
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (clk_cnt == LAST) begin
          sample    = 1'b1;
          state_nxt = rx_s ? S_IDLE : S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        // A line held low after a bad stop bit must not look like a new start.
        if (rx_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
      par_bad <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);

      // The counter restarts at every sample point, so each later sample
      // lands exactly CLKS_PER_BIT cycles after the previous one.
      if (state == S_IDLE || state == S_WAIT_IDLE || sample) clk_cnt <= '0;
      else                                                   clk_cnt <= clk_cnt + CW'(1);

      if (state == S_START) begin
        bit_cnt <= 3'd0;
        par_bad <= 1'b0;
      end

      if (sample && state == S_DATA) begin
        shift   <= {rx_s, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end

      // Even parity: the data bits XOR the parity bit must be 0.
      if (sample && state == S_PARITY) par_bad <= (^shift) ^ rx_s;
    end
  end

  // Result register and one-cycle pulses. Only one pulse can be raised per
  // frame, and only at the stop sample.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (sample && state == S_STOP) begin
        if (!rx_s) begin
          frame_err <= 1'b1;
        end else if (par_bad) begin
          parity_err <= 1'b1;
        end else begin
          byte_out   <= shift;
          byte_valid <= 1'b1;
        end
      end
    end
  end

endmodule
